// File: rtl/tt_um_hoene_frame_select.sv
// Frame word selector: parses a start/payload/parity word stream inside
// in_sync frames and latches the payload of the in_sel-th fresh word.
module tt_um_hoene_frame_select #(
  parameter int unsigned PAYLOAD_W  = 30,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned TEST_WORDS = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_data,
  input  logic                 in_clk,
  input  logic                 in_sync,
  input  logic [SEL_W-1:0]     in_sel,
  output logic [PAYLOAD_W-1:0] pwm_data,
  output logic                 pwm_set,
  output logic                 swap_forward_bit,
  output logic                 frame_error,
  output logic                 test_mode
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_MAX = 255;
  localparam int unsigned BIT_W   = $clog2(PAYLOAD_W + 1);

  typedef enum logic [1:0] {IDLE, START, PAYLOAD, PARITY} state_e;

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [CNT_W-1:0]     fresh_q, fresh_d;
  logic [BIT_W-1:0]     bitcnt_q, bitcnt_d;
  logic [PAYLOAD_W-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 own_q, own_d;
  logic                 own_seen_q, own_seen_d;
  logic                 armed_q, armed_d;
  logic [PAYLOAD_W-1:0] pwm_data_q, pwm_data_d;
  logic                 pwm_set_q, pwm_set_d;
  logic                 swap_q, swap_d;
  logic                 ferr_q, ferr_d;
  logic                 test_q, test_d;

  state_e               cur_state;
  logic [SEL_W-1:0]     cur_sel;
  logic [CNT_W:0]       fresh_inc;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      fresh_q    <= '0;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      own_q      <= 1'b0;
      own_seen_q <= 1'b0;
      armed_q    <= 1'b0;
      pwm_data_q <= '0;
      pwm_set_q  <= 1'b0;
      swap_q     <= 1'b0;
      ferr_q     <= 1'b0;
      test_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      fresh_q    <= fresh_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      own_q      <= own_d;
      own_seen_q <= own_seen_d;
      armed_q    <= armed_d;
      pwm_data_q <= pwm_data_d;
      pwm_set_q  <= pwm_set_d;
      swap_q     <= swap_d;
      ferr_q     <= ferr_d;
      test_q     <= test_d;
    end
  end

  // Word parser: next state, counters, payload capture and flag updates
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    fresh_d    = fresh_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    own_d      = own_q;
    own_seen_d = own_seen_q;
    armed_d    = armed_q;
    pwm_data_d = pwm_data_q;
    pwm_set_d  = 1'b0;
    ferr_d     = ferr_q;
    test_d     = test_q;
    cur_state  = state_q;
    cur_sel    = sel_q;
    fresh_inc  = {1'b0, fresh_q} + (CNT_W + 1)'(1);

    if (!in_sync) begin
      // Inter-frame gap: abort any word; also re-arms parsing after reset
      state_d    = IDLE;
      bitcnt_d   = '0;
      fresh_d    = '0;
      own_d      = 1'b0;
      own_seen_d = 1'b0;
      ferr_d     = 1'b0;
      armed_d    = 1'b1;
    end else if (armed_q) begin
      if (state_q == IDLE) begin
        cur_state = START;
        cur_sel   = in_sel;
        sel_d     = in_sel;
        state_d   = START;
      end
      if (in_clk) begin
        case (cur_state)
          START: begin
            bitcnt_d = '0;
            par_d    = 1'b0;
            state_d  = PAYLOAD;
            if (in_data) begin
              own_d = (fresh_q == CNT_W'(cur_sel)) && !own_seen_q;
              if (own_d) own_seen_d = 1'b1;
              if (fresh_q != CNT_W'(CNT_MAX)) fresh_d = fresh_inc[CNT_W-1:0];
              if (fresh_inc > (CNT_W + 1)'(TEST_WORDS)) test_d = 1'b1;
            end else begin
              own_d = 1'b0;
            end
          end
          PAYLOAD: begin
            shift_d  = PAYLOAD_W'({shift_q, in_data});
            par_d    = par_q ^ in_data;
            bitcnt_d = bitcnt_q + BIT_W'(1);
            if (bitcnt_q == BIT_W'(PAYLOAD_W - 1)) state_d = PARITY;
          end
          PARITY: begin
            state_d = START;
            if (in_data != par_q) begin
              ferr_d = 1'b1;
            end else if (own_q && !ferr_q) begin
              pwm_data_d = shift_q;
              pwm_set_d  = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    // Forwarder swaps bits until our own fresh start bit has gone by
    swap_d = in_sync && armed_q && !own_seen_d;
  end

  assign pwm_data         = pwm_data_q;
  assign pwm_set          = pwm_set_q;
  assign swap_forward_bit = swap_q;
  assign frame_error      = ferr_q;
  assign test_mode        = test_q;

endmodule

// File: tb/tb_tt_um_hoene_frame_select.sv
// Bench for tt_um_hoene_frame_select: frame-level reference model plus
// directed scenarios and randomized frames.
module tb_tt_um_hoene_frame_select;

  localparam int unsigned W  = 8;
  localparam int unsigned L  = W + 2;
  localparam int unsigned TW = 3;

  logic         clk = 1'b0;
  logic         rst_n, in_data, in_clk, in_sync;
  logic [1:0]   in_sel;
  logic [W-1:0] pwm_data;
  logic         pwm_set, swap_forward_bit, frame_error, test_mode;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  tt_um_hoene_frame_select #(.PAYLOAD_W(W), .SEL_W(2), .TEST_WORDS(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_clk(in_clk),
    .in_sync(in_sync), .in_sel(in_sel), .pwm_data(pwm_data), .pwm_set(pwm_set),
    .swap_forward_bit(swap_forward_bit), .frame_error(frame_error),
    .test_mode(test_mode)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (frame as a list of accepted bits) -----
  bit           fb[$];
  int           m_sel;
  bit           m_armed, m_frame;
  logic [W-1:0] m_pwm;
  bit           m_set, m_swap, m_ferr, m_test;

  function automatic void model_reset();
    fb.delete();
    m_sel = 0; m_armed = 0; m_frame = 0;
    m_pwm = '0; m_set = 0; m_swap = 0; m_ferr = 0; m_test = 0;
  endfunction

  // Index of the word whose start bit is the m_sel-th fresh one, or -1
  function automatic int own_index();
    int fresh = 0;
    for (int k = 0; k * L < fb.size(); k++) begin
      if (fb[k * L]) begin
        if (fresh == m_sel) return k;
        fresh++;
      end
    end
    return -1;
  endfunction

  function automatic void model_step(bit d, bit c, bit s, int sel);
    m_set = 0;
    if (!s) begin
      fb.delete(); m_frame = 0; m_armed = 1; m_ferr = 0; m_swap = 0;
      return;
    end
    if (!m_armed) return;
    if (!m_frame) begin m_frame = 1; m_sel = sel; end
    if (c) begin
      int n, k, pos, cnt;
      fb.push_back(d);
      n = fb.size(); k = (n - 1) / L; pos = (n - 1) % L;
      if (pos == 0 && d) begin
        cnt = 0;
        for (int j = 0; j <= k; j++) cnt += fb[j * L];
        if (cnt > 255) cnt = 255;
        if (cnt > TW) m_test = 1;
      end
      if (pos == L - 1) begin
        logic [W-1:0] p;
        p = '0;
        for (int i = 1; i <= W; i++) p = {p[W-2:0], fb[k * L + i]};
        if (fb[k * L + L - 1] != ^p) m_ferr = 1;
        else if (own_index() == k && !m_ferr) begin m_pwm = p; m_set = 1; end
      end
    end
    m_swap = (own_index() < 0);
  endfunction

  // ---------------- checking ----------------------------------------------
  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("pwm_data", 32'(pwm_data), 32'(m_pwm));
      cmp("pwm_set", 32'(pwm_set), 32'(m_set));
      cmp("swap_forward_bit", 32'(swap_forward_bit), 32'(m_swap));
      cmp("frame_error", 32'(frame_error), 32'(m_ferr));
      cmp("test_mode", 32'(test_mode), 32'(m_test));
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic step(bit d, bit c, bit s, logic [1:0] sel);
    @(negedge clk); #1;
    in_data = d; in_clk = c; in_sync = s; in_sel = sel;
    if (rst_n) model_step(d, c, s, int'(sel));
  endtask

  task automatic send_word(bit st, logic [W-1:0] p, bit par, logic [1:0] sel);
    step(st, 1'b1, 1'b1, sel);
    for (int i = W - 1; i >= 0; i--) step(p[i], 1'b1, 1'b1, sel);
    step(par, 1'b1, 1'b1, sel);
  endtask

  task automatic gap(int n);
    for (int i = 0; i < n; i++)
      step(1'($urandom), 1'($urandom), 1'b0, 2'($urandom));
  endtask

  task automatic idle(logic [1:0] sel);
    step(1'($urandom), 1'b0, 1'b1, sel);
  endtask

  // ---------------- main sequence ------------------------------------------
  initial begin
    bit  wb[$];
    int  nw, abort_at;
    logic [W-1:0] p;
    bit st;

    rst_n = 1'b1; in_data = 0; in_clk = 0; in_sync = 0; in_sel = 0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    cmp("reset pwm_data", 32'(pwm_data), 0);
    cmp("reset test_mode", 32'(test_mode), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Own word 0xA5 with sel=0
    gap(3);
    send_word(1'b1, 8'hA5, 1'b0, 2'd0);
    idle(2'd0);
    cmp("a5 pwm_set", 32'(pwm_set), 1);
    cmp("a5 pwm_data", 32'(pwm_data), 32'hA5);
    cmp("a5 frame_error", 32'(frame_error), 0);
    idle(2'd0);
    cmp("a5 pwm_set pulse end", 32'(pwm_set), 0);

    // sel=1, consumed word then two fresh words; in_sel changes after latch
    gap(2);
    idle(2'd1);
    idle(2'd2);
    cmp("sel1 swap at frame start", 32'(swap_forward_bit), 1);
    send_word(1'b0, 8'hFF, 1'b0, 2'd3);
    send_word(1'b1, 8'h11, 1'b0, 2'd0);
    cmp("sel1 swap before own", 32'(swap_forward_bit), 1);
    send_word(1'b1, 8'h3C, 1'b0, 2'd2);
    cmp("sel1 swap after own", 32'(swap_forward_bit), 0);
    idle(2'd0);
    cmp("sel1 pwm_data", 32'(pwm_data), 32'h3C);
    cmp("sel1 pwm_set", 32'(pwm_set), 1);

    // Parity error on own word
    gap(2);
    send_word(1'b1, 8'hA5, 1'b1, 2'd0);
    idle(2'd0);
    cmp("perr frame_error", 32'(frame_error), 1);
    cmp("perr pwm_set", 32'(pwm_set), 0);
    cmp("perr pwm_data kept", 32'(pwm_data), 32'h3C);
    gap(2);
    cmp("perr cleared by gap", 32'(frame_error), 0);

    // Abort after 4 payload bits, then a clean frame
    step(1'b1, 1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 2'd0);
    gap(2);
    cmp("abort frame_error", 32'(frame_error), 0);
    cmp("abort pwm_set", 32'(pwm_set), 0);
    cmp("abort pwm_data", 32'(pwm_data), 32'h3C);
    send_word(1'b1, 8'h0F, 1'b0, 2'd0);
    idle(2'd0);
    cmp("after abort pwm_data", 32'(pwm_data), 32'h0F);

    // Test mode: 4th fresh word exceeds TEST_WORDS=3
    gap(2);
    send_word(1'b1, 8'h01, 1'b1, 2'd3);
    send_word(1'b1, 8'h03, 1'b0, 2'd3);
    send_word(1'b1, 8'h07, 1'b1, 2'd3);
    cmp("test_mode after 3", 32'(test_mode), 0);
    step(1'b1, 1'b1, 1'b1, 2'd3);
    step(1'b0, 1'b1, 1'b1, 2'd3);
    cmp("test_mode after 4", 32'(test_mode), 1);
    gap(3);
    cmp("test_mode sticky", 32'(test_mode), 1);

    // Asynchronous reset mid-payload
    send_word(1'b1, 8'hA5, 1'b0, 2'd0);
    step(1'b1, 1'b1, 1'b1, 2'd0);
    step(1'b1, 1'b1, 1'b1, 2'd0);
    step(1'b0, 1'b1, 1'b1, 2'd0);
    cmp("pre-reset pwm_data", 32'(pwm_data), 32'hA5);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    cmp("async rst pwm_data", 32'(pwm_data), 0);
    cmp("async rst swap", 32'(swap_forward_bit), 0);
    cmp("async rst test_mode", 32'(test_mode), 0);
    cmp("async rst frame_error", 32'(frame_error), 0);
    cmp("async rst pwm_set", 32'(pwm_set), 0);
    step(1'b1, 1'b1, 1'b1, 2'd0);
    step(1'b1, 1'b1, 1'b1, 2'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    send_word(1'b1, 8'h55, 1'b0, 2'd0);
    idle(2'd0);
    cmp("no parse before gap", 32'(pwm_data), 0);
    gap(2);
    send_word(1'b1, 8'h33, 1'b0, 2'd0);
    idle(2'd0);
    cmp("parse after gap", 32'(pwm_data), 32'h33);

    // Randomized frames with idle strobes, consumed words and aborts
    for (int f = 0; f < 200; f++) begin
      gap(int'($urandom_range(1, 3)));
      nw = int'($urandom_range(1, 5));
      wb.delete();
      for (int w = 0; w < nw; w++) begin
        st = ($urandom % 3) != 0;
        p  = W'($urandom);
        wb.push_back(st);
        for (int i = W - 1; i >= 0; i--) wb.push_back(p[i]);
        wb.push_back((^p) ^ (($urandom % 8) == 0));
      end
      abort_at = (($urandom % 6) == 0) ? int'($urandom_range(0, nw * L - 1)) : -1;
      for (int i = 0; i < wb.size(); i++) begin
        if (i == abort_at) break;
        while (($urandom % 3) == 0) idle(2'($urandom));
        step(wb[i], 1'b1, 1'b1, 2'($urandom));
      end
      idle(2'($urandom));
    end
    gap(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
